pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard controller (slave).
// It carries the ID/EX hazard inputs and the stall/flush/hold control outputs.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       ex_mdu_start;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_hold;
  logic       mdu_done;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_mdu_start,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, mdu_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_mdu_start,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, mdu_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and multi-cycle MDU hold.
// Defining PIPE_HAZARD_STATS_EN adds the stall_cycles / flush_count statistics outputs.
`ifndef IF_ID_WRITE_ON
`define IF_ID_WRITE_ON 1'b1
`endif
`ifndef IF_ID_WRITE_OFF
`define IF_ID_WRITE_OFF 1'b0
`endif
`ifndef IF_ID_FLUSH_ON
`define IF_ID_FLUSH_ON 1'b1
`endif
`ifndef IF_ID_FLUSH_OFF
`define IF_ID_FLUSH_OFF 1'b0
`endif

module pipe_hazard_ctrl #(
  parameter int MDU_LATENCY = 32
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(MDU_LATENCY - 1);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       load_use_s;
  logic       pc_write_s;
  logic       if_id_write_s;
  logic       if_id_flush_s;
  logic       id_ex_flush_s;
  logic       ex_hold_s;
  logic       mdu_done_s;

  // Load-use detection; register 0 is hardwired and never creates a dependency.
  always_comb begin
    load_use_s = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                 ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                  (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));
  end

  // Control outputs decoded from the current state and this cycle's hazard inputs.
  always_comb begin
    pc_write_s    = 1'b1;
    if_id_write_s = `IF_ID_WRITE_ON;
    if_id_flush_s = `IF_ID_FLUSH_OFF;
    id_ex_flush_s = 1'b0;
    ex_hold_s     = 1'b0;
    mdu_done_s    = 1'b0;
    case (state_r)
      MDU_BUSY: begin
        pc_write_s    = 1'b0;
        if_id_write_s = `IF_ID_WRITE_OFF;
        ex_hold_s     = 1'b1;
      end
      RUN, MDU_DONE: begin
        mdu_done_s = (state_r == MDU_DONE);
        if (hz.ex_branch_taken) begin
          if_id_flush_s = `IF_ID_FLUSH_ON;
          id_ex_flush_s = 1'b1;
        end else if (load_use_s) begin
          pc_write_s    = 1'b0;
          if_id_write_s = `IF_ID_WRITE_OFF;
          id_ex_flush_s = 1'b1;
        end else begin
          pc_write_s    = 1'b1;
          if_id_write_s = `IF_ID_WRITE_ON;
        end
      end
      default: begin
        pc_write_s    = 1'b1;
        if_id_write_s = `IF_ID_WRITE_ON;
      end
    endcase
  end

  // State machine and MDU busy down-counter; a taken branch suppresses an MDU start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RUN;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (!hz.ex_branch_taken && hz.ex_mdu_start) begin
            state_r <= MDU_BUSY;
            cnt_r   <= LAT_M1;
          end else begin
            state_r <= RUN;
            cnt_r   <= 8'd0;
          end
        end
        MDU_BUSY: begin
          if (cnt_r <= 8'd1) begin
            state_r <= MDU_DONE;
            cnt_r   <= 8'd0;
          end else begin
            state_r <= MDU_BUSY;
            cnt_r   <= cnt_r - 8'd1;
          end
        end
        MDU_DONE: begin
          state_r <= RUN;
          cnt_r   <= 8'd0;
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

  assign hz.pc_write    = pc_write_s;
  assign hz.if_id_write = if_id_write_s;
  assign hz.if_id_flush = if_id_flush_s;
  assign hz.id_ex_flush = id_ex_flush_s;
  assign hz.ex_hold     = ex_hold_s;
  assign hz.mdu_done    = mdu_done_s;

`ifdef PIPE_HAZARD_STATS_EN
  // Free-running statistics; both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_write_s) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (if_id_flush_s == `IF_ID_FLUSH_ON) begin
        flush_count <= flush_count + 32'd1;
      end else begin
        flush_count <= flush_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard/MDU/reset cases then random traffic
// checked against a cycle-scheduled reference model.
`ifndef IF_ID_WRITE_ON
`define IF_ID_WRITE_ON 1'b1
`endif
`ifndef IF_ID_WRITE_OFF
`define IF_ID_WRITE_OFF 1'b0
`endif
`ifndef IF_ID_FLUSH_ON
`define IF_ID_FLUSH_ON 1'b1
`endif
`ifndef IF_ID_FLUSH_OFF
`define IF_ID_FLUSH_OFF 1'b0
`endif

module tb_pipe_hazard_ctrl;
  localparam int L = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   busy_until;
  int   done_at;
  logic [31:0] stall_m;
  logic [31:0] flush_m;

  pipe_hazard_ctrl_if hz ();

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] sc;
  logic [31:0] fc;
`endif

  pipe_hazard_ctrl #(.MDU_LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .stall_cycles (sc),
    .flush_count  (fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy_until = -1;
    done_at    = -1;
    stall_m    = 32'd0;
    flush_m    = 32'd0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pc"},    {31'd0, hz.pc_write},    32'd1);
    chk({tag, "_ifw"},   {31'd0, hz.if_id_write}, {31'd0, `IF_ID_WRITE_ON});
    chk({tag, "_iff"},   {31'd0, hz.if_id_flush}, {31'd0, `IF_ID_FLUSH_OFF});
    chk({tag, "_idf"},   {31'd0, hz.id_ex_flush}, 32'd0);
    chk({tag, "_hold"},  {31'd0, hz.ex_hold},     32'd0);
    chk({tag, "_done"},  {31'd0, hz.mdu_done},    32'd0);
`ifdef PIPE_HAZARD_STATS_EN
    chk({tag, "_stall"}, sc, 32'd0);
    chk({tag, "_flush"}, fc, 32'd0);
`endif
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then advance the model.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic mr, input logic [4:0] ert,
                      input logic br, input logic ms);
    logic busy, done, lu;
    logic e_pc, e_ifw, e_iff, e_idf, e_hold;
    @(negedge clk);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rs = urs; hz.id_uses_rt = urt;
    hz.ex_mem_read = mr; hz.ex_rt = ert; hz.ex_branch_taken = br; hz.ex_mdu_start = ms;
    #1;
    busy = (cyc <= busy_until);
    done = (cyc == done_at);
    lu   = mr && (ert != 5'd0) && ((urs && rs == ert) || (urt && rt == ert));
    if (busy) begin
      e_pc = 1'b0; e_ifw = `IF_ID_WRITE_OFF; e_iff = `IF_ID_FLUSH_OFF; e_idf = 1'b0; e_hold = 1'b1;
    end else if (br) begin
      e_pc = 1'b1; e_ifw = `IF_ID_WRITE_ON; e_iff = `IF_ID_FLUSH_ON; e_idf = 1'b1; e_hold = 1'b0;
    end else if (lu) begin
      e_pc = 1'b0; e_ifw = `IF_ID_WRITE_OFF; e_iff = `IF_ID_FLUSH_OFF; e_idf = 1'b1; e_hold = 1'b0;
    end else begin
      e_pc = 1'b1; e_ifw = `IF_ID_WRITE_ON; e_iff = `IF_ID_FLUSH_OFF; e_idf = 1'b0; e_hold = 1'b0;
    end
    chk("pc_write",    {31'd0, hz.pc_write},    {31'd0, e_pc});
    chk("if_id_write", {31'd0, hz.if_id_write}, {31'd0, e_ifw});
    chk("if_id_flush", {31'd0, hz.if_id_flush}, {31'd0, e_iff});
    chk("id_ex_flush", {31'd0, hz.id_ex_flush}, {31'd0, e_idf});
    chk("ex_hold",     {31'd0, hz.ex_hold},     {31'd0, e_hold});
    chk("mdu_done",    {31'd0, hz.mdu_done},    {31'd0, done});
`ifdef PIPE_HAZARD_STATS_EN
    chk("stall_cycles", sc, stall_m);
    chk("flush_count",  fc, flush_m);
`endif
    if (!busy && !done && !br && ms) begin
      busy_until = cyc + L - 1;
      done_at    = cyc + L;
    end
    if (!e_pc) stall_m = stall_m + 32'd1;
    if (e_iff == `IF_ID_FLUSH_ON) flush_m = flush_m + 32'd1;
    cyc++;
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    model_reset();
    reset = 1'b0;
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rt = 5'd0; hz.ex_branch_taken = 1'b0; hz.ex_mdu_start = 1'b0;
    #2;
    chk_idle("reset");
    @(negedge clk);
    #2 reset = 1'b1;

    // MDU pulse from a clean reset: 3 hold cycles then one done pulse.
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < L + 1; i++) idle();
`ifdef PIPE_HAZARD_STATS_EN
    chk("mdu_stall_total", sc, 32'd3);
    chk("mdu_flush_total", fc, 32'd0);
`endif

    // Load-use on rs, then ex_rt==0, rt path, unused operands.
    step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    idle();
    step(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    step(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    // Branch beats load-use and beats an MDU start.
    step(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    idle();

    // MDU with noise on every input while busy, and a start attempt in the done cycle.
    step(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1);
    for (int i = 0; i < L - 1; i++) step(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle();
    idle();

    // Reset between clock edges while the MDU is busy.
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle();
    #1 reset = 1'b0;
    #1;
    chk_idle("mid_mdu_reset");
    model_reset();
    #1 reset = 1'b1;
    for (int i = 0; i < L + 1; i++) idle();

    // Random traffic over a small register set so hazards collide often.
    for (int i = 0; i < 600; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
